// File: rtl/tx_port_gate_reader_64.sv
// tx_port_gate_reader_64
// Read-side parser for the TX gate FIFO stream. It pops 65-bit words from a
// show-ahead FIFO. Each transaction is a header marker sent twice, then data
// words, then an end marker sent twice. The parser reports the header as a
// start event, forwards the payload as a valid/ready stream, and reports the
// received length as a done event.
module tx_port_gate_reader_64 #(
  parameter int C_DATA_WIDTH      = 64,
  parameter int C_FIFO_DATA_WIDTH = C_DATA_WIDTH + 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [C_FIFO_DATA_WIDTH-1:0] RD_DATA,
  input  logic                         RD_EMPTY,
  output logic                         RD_EN,
  output logic                         TXN_START,
  output logic [31:0]                  TXN_LEN,
  output logic [30:0]                  TXN_OFF,
  output logic                         TXN_LAST,
  output logic                         TXN_OPEN,
  output logic [C_DATA_WIDTH-1:0]      DATA,
  output logic                         DATA_VALID,
  input  logic                         DATA_READY,
  output logic                         DONE,
  output logic [31:0]                  DONE_WORDS,
  output logic                         ERR
);

  // The state encoding alone tells a header apart from an end marker,
  // because the all-zero header and the end marker are the same word.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR2 = 2'd1,
    S_DATA = 2'd2,
    S_END2 = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_txn_start;
  logic [31:0]             r_txn_len;
  logic [30:0]             r_txn_off;
  logic                    r_txn_last;
  logic                    r_txn_open;
  logic [C_DATA_WIDTH-1:0] r_data;
  logic                    r_data_valid;
  logic                    r_done;
  logic [31:0]             r_done_words;
  logic                    r_err;
  logic [30:0]             r_beats;

  logic                    w_pop;
  logic                    w_marker;
  logic                    w_handshake;
  logic [C_DATA_WIDTH-1:0] w_payload;

  // A word is popped only when the output register is free or draining this
  // cycle. Every word type, markers included, therefore waits behind a
  // stalled beat, so DONE can never overtake the last payload handshake.
  assign w_pop       = !RST && !RD_EMPTY && (!r_data_valid || DATA_READY);
  assign w_marker    = RD_DATA[C_DATA_WIDTH];
  assign w_payload   = RD_DATA[C_DATA_WIDTH-1:0];
  assign w_handshake = r_data_valid && DATA_READY;

  assign RD_EN      = w_pop;
  assign TXN_START  = r_txn_start;
  assign TXN_LEN    = r_txn_len;
  assign TXN_OFF    = r_txn_off;
  assign TXN_LAST   = r_txn_last;
  assign TXN_OPEN   = r_txn_open;
  assign DATA       = r_data;
  assign DATA_VALID = r_data_valid;
  assign DONE       = r_done;
  assign DONE_WORDS = r_done_words;
  assign ERR        = r_err;

  // Parser FSM with registered outputs; pulses last exactly one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_txn_start  <= 1'b0;
      r_txn_len    <= '0;
      r_txn_off    <= '0;
      r_txn_last   <= 1'b0;
      r_txn_open   <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;
      r_done_words <= '0;
      r_err        <= 1'b0;
      r_beats      <= '0;
    end else begin
      r_txn_start <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;

      // A consumed beat frees the register unless a new beat loads below.
      if (w_handshake) begin
        r_data_valid <= 1'b0;
      end

      if (w_pop) begin
        case (r_state)
          S_IDLE: begin
            if (w_marker) begin
              r_txn_len    <= RD_DATA[63:32];
              r_txn_off    <= RD_DATA[31:1];
              r_txn_last   <= RD_DATA[0];
              r_beats      <= '0;
              r_done_words <= '0;
              r_txn_start  <= 1'b1;
              r_txn_open   <= 1'b1;
              r_state      <= S_HDR2;
            end else begin
              r_err <= 1'b1;
            end
          end

          S_HDR2: begin
            // A missing duplicate header is tolerated: the first data word
            // is simply treated as payload.
            if (!w_marker) begin
              r_data       <= w_payload;
              r_data_valid <= 1'b1;
              r_beats      <= r_beats + 31'd1;
            end
            r_state <= S_DATA;
          end

          S_DATA: begin
            if (w_marker) begin
              r_done       <= 1'b1;
              r_done_words <= {r_beats, 1'b0};
              r_state      <= S_END2;
            end else begin
              r_data       <= w_payload;
              r_data_valid <= 1'b1;
              r_beats      <= r_beats + 31'd1;
            end
          end

          S_END2: begin
            // A data word where the duplicate end marker belongs is dropped.
            if (!w_marker) begin
              r_err <= 1'b1;
            end
            r_txn_open <= 1'b0;
            r_state    <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_port_gate_reader_64.sv
// Bench for tx_port_gate_reader_64: a stream-level model predicts headers,
// payload beats, done lengths and error counts; a per-cycle monitor checks
// the DUT against it; directed tests pin the model with literal values.
module tb_tx_port_gate_reader_64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [64:0] RD_DATA = '0;
  logic        RD_EMPTY = 1'b1;
  logic        RD_EN;
  logic        TXN_START;
  logic [31:0] TXN_LEN;
  logic [30:0] TXN_OFF;
  logic        TXN_LAST;
  logic        TXN_OPEN;
  logic [63:0] DATA;
  logic        DATA_VALID;
  logic        DATA_READY = 1'b1;
  logic        DONE;
  logic [31:0] DONE_WORDS;
  logic        ERR;

  tx_port_gate_reader_64 #(.C_DATA_WIDTH(64), .C_FIFO_DATA_WIDTH(65)) dut (
    .CLK(CLK), .RST(RST), .RD_DATA(RD_DATA), .RD_EMPTY(RD_EMPTY), .RD_EN(RD_EN),
    .TXN_START(TXN_START), .TXN_LEN(TXN_LEN), .TXN_OFF(TXN_OFF), .TXN_LAST(TXN_LAST),
    .TXN_OPEN(TXN_OPEN), .DATA(DATA), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .DONE(DONE), .DONE_WORDS(DONE_WORDS), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus FIFO (main writes wr_ptr, driver owns rd_ptr).
  logic [64:0] stim_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  // Model expectations (main writes *_wr, monitor owns *_rd).
  logic [31:0] exp_len  [0:255];
  logic [30:0] exp_off  [0:255];
  logic        exp_last [0:255];
  logic [63:0] exp_data [0:255];
  logic [31:0] exp_dw   [0:255];
  int          exp_dend [0:255];
  int hdr_wr = 0, hdr_rd = 0;
  int data_wr = 0, data_rd = 0;
  int done_wr = 0, done_rd = 0;
  int exp_err = 0;
  int m_phase = 0;
  int m_beats = 0;

  // Stream-level model: interprets each word from its position in the stream.
  task automatic model_step(input logic [64:0] w);
    logic mk;
    mk = w[64];
    case (m_phase)
      0: if (mk) begin
           exp_len[hdr_wr] = w[63:32]; exp_off[hdr_wr] = w[31:1]; exp_last[hdr_wr] = w[0];
           hdr_wr++; m_beats = 0; m_phase = 1;
         end else exp_err++;
      1: begin
           if (!mk) begin exp_data[data_wr] = w[63:0]; data_wr++; m_beats++; end
           m_phase = 2;
         end
      2: if (mk) begin
           exp_dw[done_wr] = 32'(m_beats * 2); exp_dend[done_wr] = data_wr; done_wr++;
           m_phase = 3;
         end else begin
           exp_data[data_wr] = w[63:0]; data_wr++; m_beats++;
         end
      default: begin
           if (!mk) exp_err++;
           m_phase = 0;
         end
    endcase
  endtask

  task automatic send(input logic [64:0] w);
    stim_mem[wr_ptr] = w; wr_ptr++;
    model_step(w);
  endtask
  task automatic hdr(input logic [31:0] len, input logic [30:0] off, input logic last);
    send({1'b1, len, off, last});
  endtask
  task automatic dat(input logic [63:0] x);
    send({1'b0, x});
  endtask
  task automatic endm();
    send({1'b1, 64'h0});
  endtask

  // Driver controls.
  bit gap_mode = 0;
  bit hold_ready_low = 0;
  int stall_at = 0;
  int hs_drv = 0;
  int gap_ctr = 0;
  int stall_cnt = 0;
  bit will_pop = 0;
  bit will_hs = 0;

  // Inputs change 1 time unit after the active edge.
  always @(posedge CLK) begin
    #1;
    if (RST) begin
      rd_ptr = wr_ptr; gap_ctr = 0; stall_cnt = 0;
    end else begin
      if (will_pop && rd_ptr < wr_ptr) begin
        rd_ptr++; gap_ctr = gap_mode ? 1 : 0;
      end else if (gap_ctr > 0) gap_ctr--;
      if (will_hs) hs_drv++;
      if (will_hs && hs_drv == stall_at) stall_cnt = 5;
      else if (stall_cnt > 0) stall_cnt--;
    end
    RD_EMPTY   = (rd_ptr >= wr_ptr) || (gap_ctr > 0);
    RD_DATA    = (rd_ptr < wr_ptr) ? stim_mem[rd_ptr] : '0;
    DATA_READY = (stall_cnt == 0) && !hold_ready_low;
  end

  // Monitor observations.
  int cyc = 0, n_start = 0, n_done = 0, n_err = 0, n_hs = 0, n_stall = 0, n_stall_pop = 0;
  int hs_cyc [0:255];
  logic [31:0] obs_len = '0;
  logic [30:0] obs_off = '0;
  logic        obs_last = 1'b0;
  logic [31:0] obs_dw = '0;
  logic        prev_dv = 0, prev_rdy = 1, prev_start = 0;
  logic [63:0] prev_data = '0;

  // Compare process, sampling on the inactive edge.
  always @(negedge CLK) begin
    cyc++;
    will_pop = RD_EN;
    will_hs  = DATA_VALID && DATA_READY;
    if (RST) begin
      hdr_rd = hdr_wr; data_rd = data_wr; done_rd = done_wr;
      prev_dv = 0; prev_rdy = 1; prev_start = 0;
    end else begin
      chk("rd_en_rule", RD_EN, !RD_EMPTY && (!DATA_VALID || DATA_READY));
      chk("start_done_excl", TXN_START && DONE, 0);
      chk("err_alone", ERR && (TXN_START || DONE), 0);
      if (prev_start) chk("start_one_cycle", TXN_START, 0);
      if (prev_dv && !prev_rdy) begin
        chk("stall_data_hold", DATA, prev_data);
        chk("stall_valid_hold", DATA_VALID, 1);
      end
      if (TXN_START) begin
        n_start++;
        chk("start_expected", hdr_rd < hdr_wr, 1);
        if (hdr_rd < hdr_wr) begin
          chk("txn_len", TXN_LEN, exp_len[hdr_rd]);
          chk("txn_off", TXN_OFF, exp_off[hdr_rd]);
          chk("txn_last", TXN_LAST, exp_last[hdr_rd]);
          chk("txn_open_at_start", TXN_OPEN, 1);
          hdr_rd++;
        end
        obs_len = TXN_LEN; obs_off = TXN_OFF; obs_last = TXN_LAST;
      end
      if (will_hs) begin
        hs_cyc[n_hs] = cyc; n_hs++;
        chk("beat_expected", data_rd < data_wr, 1);
        if (data_rd < data_wr) begin
          chk("data", DATA, exp_data[data_rd]);
          data_rd++;
        end
      end
      if (DATA_VALID && !DATA_READY) begin
        n_stall++;
        if (RD_EN) n_stall_pop++;
      end
      if (DONE) begin
        n_done++;
        obs_dw = DONE_WORDS;
        chk("done_expected", done_rd < done_wr, 1);
        if (done_rd < done_wr) begin
          chk("done_words", DONE_WORDS, exp_dw[done_rd]);
          chk("done_after_beats", data_rd, exp_dend[done_rd]);
          done_rd++;
        end
        chk("done_no_valid", DATA_VALID, 0);
        chk("open_at_done", TXN_OPEN, 1);
      end
      if (ERR) n_err++;
      prev_dv = DATA_VALID; prev_rdy = DATA_READY; prev_data = DATA; prev_start = TXN_START;
    end
  end

  task automatic drain(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (rd_ptr == wr_ptr && RD_EMPTY && !DATA_VALID && !TXN_OPEN) begin ok = 1; break; end
    end
    chk({nm, "_drain"}, ok, 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rd_en"}, RD_EN, 0);
    chk({nm, "_start"}, TXN_START, 0);
    chk({nm, "_len"}, TXN_LEN, 0);
    chk({nm, "_off"}, TXN_OFF, 0);
    chk({nm, "_last"}, TXN_LAST, 0);
    chk({nm, "_open"}, TXN_OPEN, 0);
    chk({nm, "_data"}, DATA, 0);
    chk({nm, "_valid"}, DATA_VALID, 0);
    chk({nm, "_done"}, DONE, 0);
    chk({nm, "_done_words"}, DONE_WORDS, 0);
    chk({nm, "_err"}, ERR, 0);
  endtask

  initial begin
    int s0, d0, e0, h0, st0;
    bit ok;

    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST = 0;
    repeat (2) @(negedge CLK);

    // Basic transaction, back to back, consumer always ready.
    h0 = n_hs; s0 = n_start; d0 = n_done;
    hdr(32'd6, 31'h10, 1'b1); hdr(32'd6, 31'h10, 1'b1);
    dat(64'hA); dat(64'hB); dat(64'hC); endm(); endm();
    drain("basic");
    chk("basic_len_lit", obs_len, 32'd6);
    chk("basic_off_lit", obs_off, 31'h10);
    chk("basic_last_lit", obs_last, 1);
    chk("basic_dw_lit", obs_dw, 32'd6);
    chk("basic_beats_lit", n_hs - h0, 3);
    chk("basic_no_bubbles", hs_cyc[h0 + 2] - hs_cyc[h0], 2);
    chk("basic_starts", n_start - s0, 1);
    chk("basic_open_low", TXN_OPEN, 0);
    $display("txn basic: len=%0d off=%0h last=%0d done_words=%0d", obs_len, obs_off, obs_last, obs_dw);

    // All-zero header pair followed by the end markers.
    h0 = n_hs; s0 = n_start; d0 = n_done;
    hdr(32'd0, 31'd0, 1'b0); hdr(32'd0, 31'd0, 1'b0); endm(); endm();
    drain("zero");
    chk("zero_starts", n_start - s0, 1);
    chk("zero_dones", n_done - d0, 1);
    chk("zero_dw_lit", obs_dw, 32'd0);
    chk("zero_no_beats", n_hs - h0, 0);
    $display("txn zero-header: starts=%0d dones=%0d done_words=%0d", n_start - s0, n_done - d0, obs_dw);

    // Four beats with the consumer stalling for five cycles after beat 1.
    h0 = n_hs; st0 = n_stall;
    stall_at = hs_drv + 1;
    hdr(32'd8, 31'h40, 1'b0); hdr(32'd8, 31'h40, 1'b0);
    dat(64'h1111_0001); dat(64'h2222_0002); dat(64'h3333_0003); dat(64'h4444_0004);
    endm(); endm();
    drain("stall");
    chk("stall_cycles_lit", n_stall - st0, 5);
    chk("stall_no_pop", n_stall_pop, 0);
    chk("stall_beats_lit", n_hs - h0, 4);
    chk("stall_dw_lit", obs_dw, 32'd8);
    $display("txn stall: beats=%0d stall_cycles=%0d done_words=%0d", n_hs - h0, n_stall - st0, obs_dw);

    // Empty FIFO between every word.
    gap_mode = 1; h0 = n_hs; d0 = n_done;
    hdr(32'd6, 31'h2, 1'b0); hdr(32'd6, 31'h2, 1'b0);
    dat(64'hA); dat(64'hB); dat(64'hC); endm(); endm();
    drain("gap");
    gap_mode = 0;
    chk("gap_beats_lit", n_hs - h0, 3);
    chk("gap_dones", n_done - d0, 1);
    chk("gap_dw_lit", obs_dw, 32'd6);
    $display("txn gaps: beats=%0d done_words=%0d", n_hs - h0, obs_dw);

    // Protocol errors: data in IDLE, data where the second end marker belongs.
    e0 = n_err; s0 = n_start; d0 = n_done; h0 = n_hs;
    dat(64'hDEAD);
    hdr(32'd2, 31'h4, 1'b0); hdr(32'd2, 31'h4, 1'b0); dat(64'h11); endm();
    dat(64'hBAD);
    hdr(32'd2, 31'h8, 1'b1); hdr(32'd2, 31'h8, 1'b1); dat(64'h22); endm(); endm();
    drain("err");
    chk("err_pulses_lit", n_err - e0, 2);
    chk("err_starts", n_start - s0, 2);
    chk("err_dones", n_done - d0, 2);
    chk("err_beats_lit", n_hs - h0, 2);
    chk("err_next_off_lit", obs_off, 31'h8);
    $display("txn errors: err=%0d starts=%0d beats=%0d", n_err - e0, n_start - s0, n_hs - h0);

    // Asynchronous reset in the middle of a stalled payload.
    hold_ready_low = 1;
    hdr(32'd8, 31'h20, 1'b0); hdr(32'd8, 31'h20, 1'b0);
    dat(64'h1111); dat(64'h2222); dat(64'h3333); dat(64'h4444);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (DATA_VALID) begin ok = 1; break; end
    end
    chk("rst_wait_valid", ok, 1);
    chk("rst_pre_open", TXN_OPEN, 1);
    @(posedge CLK); #3;
    RST = 1; #1;
    chk_all_zero("async_rst");
    @(negedge CLK);
    m_phase = 0; hold_ready_low = 0;
    repeat (2) @(negedge CLK);
    RST = 0;
    repeat (2) @(negedge CLK);
    hdr(32'd2, 31'h0, 1'b0); hdr(32'd2, 31'h0, 1'b0); dat(64'h55); endm(); endm();
    drain("post_rst");
    chk("post_rst_dw_lit", obs_dw, 32'd2);
    chk("post_rst_len_lit", obs_len, 32'd2);
    $display("txn post-reset: len=%0d done_words=%0d", obs_len, obs_dw);

    chk("err_total", n_err, exp_err);
    chk("hdrs_consumed", hdr_rd, hdr_wr);
    chk("beats_consumed", data_rd, data_wr);
    chk("dones_consumed", done_rd, done_wr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
